// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling controller that fills one cache block from
// a 4-cycle-latency, 16-bit, byte-addressed main memory. On a miss it issues
// BLOCK_WORDS back-to-back word reads, writes each returned word into the
// data array, writes the tag array with the last word, and holds fsm_busy
// high until the block is complete.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic [15:0]           memory_data,
  input  logic                  memory_data_valid,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  fsm_busy,
  output logic                  write_data_array,
  output logic [ADDR_WIDTH-1:0] fill_address,
  output logic [15:0]           fill_data,
  output logic                  write_tag_array
);

  // Byte-offset bits inside a block, and a counter width that can hold
  // BLOCK_WORDS itself (issue_cnt saturates there).
  localparam int OFFSET_BITS = $clog2(2 * BLOCK_WORDS);
  localparam int CNT_W       = $clog2(BLOCK_WORDS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Block alignment relies on the block size being a power of two.
  if ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_block_words
    $error("BLOCK_WORDS must be a power of two");
  end

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   base;
  logic [CNT_W-1:0]        issue_cnt;
  logic [CNT_W-1:0]        recv_cnt;
  logic [CNT_W-1:0]        outstanding;

  logic                    issuing;
  logic                    accept;
  logic                    last_word;
  logic [ADDR_WIDTH-1:0]   issue_addr;
  logic [ADDR_WIDTH-1:0]   recv_addr;
  logic [ADDR_WIDTH-1:0]   aligned_miss;

  // Request/accept decode shared by the state update and the outputs.
  // NOTE: every signal gets a default at the top of an always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    issuing      = 1'b0;
    accept       = 1'b0;
    last_word    = 1'b0;
    issue_addr   = base + (ADDR_WIDTH'(issue_cnt) << 1);
    recv_addr    = base + (ADDR_WIDTH'(recv_cnt) << 1);
    aligned_miss = {miss_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    if (state == FILL) begin
      issuing = (issue_cnt < CNT_FULL);
      // A return is only ours if a request is still in flight; anything else
      // is a stale word from a fill that a reset abandoned. While reset is
      // held the fill is being abandoned too, so nothing is accepted.
      accept    = rst_n && memory_data_valid && (outstanding != '0);
      last_word = accept && (recv_cnt == CNT_LAST);
    end
  end

  // State, block base and the issue/receive/outstanding counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      outstanding <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_detected) begin
            base        <= aligned_miss;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            outstanding <= '0;
            state       <= FILL;
          end
        end
        FILL: begin
          if (issuing) begin
            issue_cnt <= issue_cnt + CNT_ONE;
          end
          if (accept) begin
            recv_cnt <= recv_cnt + CNT_ONE;
          end
          // Issue and accept in the same cycle cancel out.
          if (issuing && !accept) begin
            outstanding <= outstanding + CNT_ONE;
          end else if (!issuing && accept) begin
            outstanding <= outstanding - CNT_ONE;
          end
          if (last_word) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory request, array write strobes and busy flag.
  always_comb begin
    mem_enable       = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_address     = '0;
    fsm_busy         = (state == FILL);
    if (issuing) begin
      mem_enable     = 1'b1;
      memory_address = issue_addr;
    end
    if (accept) begin
      write_data_array = 1'b1;
      fill_address     = recv_addr;
      write_tag_array  = last_word;
    end
  end

  // This block only ever reads memory; fill data is passed straight through.
  assign mem_wr    = 1'b0;
  assign fill_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: self-checking bench for cache_fill_fsm. A behavioural
// main memory (4-cycle read pipeline with optional return gaps) serves the
// DUT; expected addresses, data, strobes and busy durations are computed
// from the block geometry and the memory's latency/gap rules.
module tb_cache_fill_fsm;

  localparam int AW = 16;
  localparam int BW = 8;
  localparam int LATENCY = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic [15:0]   memory_data;
  logic          memory_data_valid;
  logic          mem_enable;
  logic          mem_wr;
  logic [AW-1:0] memory_address;
  logic          fsm_busy;
  logic          write_data_array;
  logic [AW-1:0] fill_address;
  logic [15:0]   fill_data;
  logic          write_tag_array;

  int checks = 0;
  int errors = 0;

  cache_fill_fsm #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .mem_enable        (mem_enable),
    .mem_wr            (mem_wr),
    .memory_address    (memory_address),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .fill_address      (fill_address),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural main memory ----------------
  logic [15:0] mem_words [0:32767];
  int          gap_cycles = 0;
  bit          noise = 1'b0;
  bit          pipe_v [LATENCY];
  logic [15:0] pipe_a [LATENCY];
  logic [15:0] ret_q [$];
  int          gap_left = 0;
  logic        req_en;
  logic [15:0] req_addr;

  // Requests are sampled mid-cycle, away from the DUT's clock edge.
  always @(negedge clk) begin
    req_en   = mem_enable;
    req_addr = memory_address;
  end

  // A request seen in cycle c reaches the return queue for cycle c+4; the
  // queue then drains one word per cycle with gap_cycles idle cycles between.
  always @(posedge clk) begin
    #1;
    for (int i = LATENCY - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = req_en;
    pipe_a[0] = req_addr;
    if (pipe_v[LATENCY-1]) ret_q.push_back(pipe_a[LATENCY-1]);
    if (noise) begin
      memory_data_valid = 1'($urandom);
      memory_data       = 16'($urandom);
    end else if (ret_q.size() > 0 && gap_left == 0) begin
      logic [15:0] a;
      a = ret_q.pop_front();
      memory_data_valid = 1'b1;
      memory_data       = mem_words[a >> 1];
      gap_left          = gap_cycles;
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
      if (gap_left > 0) gap_left--;
    end
  end

  // ---------------- helpers ----------------
  task automatic start_miss(input logic [AW-1:0] addr, input bit hold);
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address  = addr;
    @(posedge clk);
    #1;
    if (!hold) miss_detected = 1'b0;
  endtask

  // Follows one fill from its first FILL cycle until the first IDLE cycle.
  task automatic check_fill(input string name, input logic [AW-1:0] addr, input int gap);
    logic [AW-1:0] base;
    logic [AW-1:0] exp_addr;
    logic          exp_en;
    int            k;
    int            nwr;
    int            busy_cycles;
    bit            done;
    base        = addr & 16'hFFF0;
    k           = 0;
    nwr         = 0;
    busy_cycles = 0;
    done        = 1'b0;
    while (!done && k < 200) begin
      @(negedge clk);
      checks++;
      if (mem_wr !== 1'b0) begin
        errors++;
        $display("FAIL %s mem_wr cycle %0d: got %b want 0", name, k, mem_wr);
      end
      if (fsm_busy !== 1'b1) begin
        done = 1'b1;
        checks++;
        if ({mem_enable, write_data_array, write_tag_array} !== 3'b000) begin
          errors++;
          $display("FAIL %s idle_outputs: got en/wr/tag=%b want 000",
                   name, {mem_enable, write_data_array, write_tag_array});
        end
      end else begin
        busy_cycles++;
        exp_en   = (k < BW);
        exp_addr = exp_en ? 16'(base + 2 * k) : 16'h0000;
        checks++;
        if ({mem_enable, memory_address} !== {exp_en, exp_addr}) begin
          errors++;
          $display("FAIL %s issue cycle %0d: got en=%b addr=%h want en=%b addr=%h",
                   name, k, mem_enable, memory_address, exp_en, exp_addr);
        end
        if (write_data_array === 1'b1) begin
          logic [AW-1:0] wa;
          logic [15:0]   wd;
          wa = 16'(base + 2 * nwr);
          wd = mem_words[int'(base >> 1) + nwr];
          checks++;
          if ({fill_address, fill_data, write_tag_array} !== {wa, wd, 1'(nwr == BW - 1)}) begin
            errors++;
            $display("FAIL %s write %0d: got addr=%h data=%h tag=%b want addr=%h data=%h tag=%b",
                     name, nwr, fill_address, fill_data, write_tag_array, wa, wd, nwr == BW - 1);
          end
          nwr++;
        end else begin
          checks++;
          if (write_tag_array !== 1'b0) begin
            errors++;
            $display("FAIL %s tag_without_write cycle %0d: got 1 want 0", name, k);
          end
        end
      end
      k++;
    end
    checks++;
    if (!done || busy_cycles != 12 + 7 * gap || nwr != BW) begin
      errors++;
      $display("FAIL %s summary: got busy=%0d writes=%0d ended=%0d want busy=%0d writes=%0d ended=1",
               name, busy_cycles, nwr, done, 12 + 7 * gap, BW);
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if ({fsm_busy, mem_enable, mem_wr, write_data_array, write_tag_array,
           memory_address, fill_address} !== '0) begin
        errors++;
        $display("FAIL %s cycle %0d: got busy/en/wr/wda/wta=%b maddr=%h faddr=%h want all 0",
                 name, i, {fsm_busy, mem_enable, mem_wr, write_data_array, write_tag_array},
                 memory_address, fill_address);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_quiet("reset", 3);
    checks++;
    if (fill_data !== memory_data) begin
      errors++;
      $display("FAIL reset fill_data: got %h want %h", fill_data, memory_data);
    end
  endtask

  task automatic test_basic_fill();
    for (int i = 0; i < BW; i++) mem_words[(16'h1000 >> 1) + i] = 16'(16'h00A0 + i);
    gap_cycles = 0;
    start_miss(16'h100A, 1'b0);
    check_fill("basic", 16'h100A, 0);
  endtask

  task automatic test_held_miss();
    gap_cycles = 0;
    start_miss(16'h2004, 1'b1);
    check_fill("held_first", 16'h2004, 0);
    check_fill("held_second", 16'h2004, 0);
    miss_detected = 1'b0;
    check_quiet("held_after", 2);
  endtask

  task automatic test_reset_mid_fill();
    int nwr;
    nwr = 0;
    gap_cycles = 0;
    start_miss(16'h3008, 1'b0);
    for (int k = 0; k < 20 && nwr < 5; k++) begin
      @(negedge clk);
      if (write_data_array === 1'b1) nwr++;
    end
    checks++;
    if (nwr != 5) begin
      errors++;
      $display("FAIL midreset writes_before_reset: got %0d want 5", nwr);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({write_data_array, write_tag_array} !== 2'b00) begin
      errors++;
      $display("FAIL midreset during_reset: got wda/wta=%b want 00",
               {write_data_array, write_tag_array});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_quiet("midreset_after", 4);
    start_miss(16'h5A5E, 1'b0);
    check_fill("midreset_refill", 16'h5A5E, 0);
  endtask

  task automatic test_gaps();
    gap_cycles = 2;
    start_miss(16'h4006, 1'b0);
    check_fill("gaps", 16'h4006, 2);
    gap_cycles = 0;
  endtask

  task automatic test_top_address();
    gap_cycles = 0;
    start_miss(16'hFFFF, 1'b0);
    check_fill("top", 16'hFFFF, 0);
  endtask

  task automatic test_idle_noise();
    noise = 1'b1;
    check_quiet("noise", 30);
    noise = 1'b0;
    check_quiet("noise_after", 2);
  endtask

  task automatic test_random_fills();
    for (int n = 0; n < 8; n++) begin
      logic [AW-1:0] a;
      int            g;
      a = 16'($urandom);
      g = int'($urandom_range(0, 2));
      for (int i = 0; i < BW; i++) mem_words[int'(a >> 4) * BW + i] = 16'($urandom);
      gap_cycles = g;
      start_miss(a, 1'b0);
      check_fill($sformatf("random%0d_a%h_g%0d", n, a, g), a, g);
      check_quiet($sformatf("random%0d_idle", n), int'($urandom_range(0, 3)));
    end
    gap_cycles = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem_words[i] = 16'($urandom);
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = '0;
    memory_data       = '0;
    memory_data_valid = 1'b0;
    test_reset();
    test_basic_fill();
    test_held_miss();
    test_reset_mid_fill();
    test_gaps();
    test_top_address();
    test_idle_noise();
    test_random_fills();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
